// File: rtl/stack_ctrl8.sv
// stack_ctrl8: 8-deep LIFO controller driving an 8x8 RAM with push/pop/swap and an 8-cycle clear
module stack_ctrl8 #(
  parameter int WORDSIZE = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic                clear,
  input  logic [WORDSIZE-1:0] push_data,
  output logic [WORDSIZE-1:0] pop_data,
  output logic                pop_valid,
  output logic [ADDR_W:0]     depth,
  output logic                full,
  output logic                empty,
  output logic                busy,
  output logic                overflow,
  output logic                underflow,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [WORDSIZE-1:0] ram_data_in,
  output logic                ram_write_en,
  input  logic [WORDSIZE-1:0] ram_data_out
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  state_t            state;
  logic [ADDR_W:0]   sp, spm;
  logic [ADDR_W-1:0] clr_cnt;
  logic              act, swap, wr, rd;
  always_comb begin
    act          = state == IDLE && !clear;
    busy         = state == CLEAR;
    full         = sp == DEPTH;
    empty        = sp == '0;
    depth        = sp;
    spm          = sp - 1'b1;
    swap         = act && push && pop && !empty;
    wr           = act && push && (!pop || empty) && !full;
    rd           = act && pop && !push && !empty;
    ram_write_en = busy || wr || swap;
    ram_addr     = busy ? clr_cnt : (swap || rd) ? spm[ADDR_W-1:0] : sp[ADDR_W-1:0];
    ram_data_in  = busy ? '0 : push_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sp        <= '0;
      clr_cnt   <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= rd || swap;
      if (rd || swap) pop_data <= ram_data_out;
      if (busy) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (&clr_cnt) begin
          sp    <= '0;
          state <= IDLE;
        end
      end else if (clear) begin
        state     <= CLEAR;
        clr_cnt   <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr) sp <= sp + 1'b1;
        else if (rd) sp <= spm;
        if (push && !pop && full) overflow <= 1'b1;
        if (pop && empty) underflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stack_ctrl8.sv
// tb_stack_ctrl8: directed test of stack_ctrl8 against a queue-based stack model and a bench RAM
module tb_stack_ctrl8;
  logic       clk = 0, rst_n = 0, push = 0, pop = 0, clear = 0;
  logic [7:0] push_data = 0, pop_data, ram_data_in, ram_data_out;
  logic [3:0] depth;
  logic [2:0] ram_addr;
  logic       pop_valid, full, empty, busy, overflow, underflow, ram_write_en;
  logic [7:0] ram [8];
  logic [7:0] mem [8];
  logic [7:0] stk [$];
  int         clr_left = 0, clr_idx = 0, total = 0, bad = 0;
  logic       m_pv = 0, m_ovf = 0, m_udf = 0;
  logic [7:0] m_pd = 0;
  bit         chk_en = 0;
  stack_ctrl8 dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clear(clear),
    .push_data(push_data), .pop_data(pop_data), .pop_valid(pop_valid),
    .depth(depth), .full(full), .empty(empty), .busy(busy),
    .overflow(overflow), .underflow(underflow), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_write_en(ram_write_en), .ram_data_out(ram_data_out)
  );
  always #5 clk = ~clk;
  assign ram_data_out = ram[ram_addr];
  always @(posedge clk) if (ram_write_en) ram[ram_addr] <= ram_data_in;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic void exp_ram(output bit we, output int a, output logic [7:0] d);
    we = 0;
    a = 0;
    d = 0;
    if (clr_left > 0) begin
      we = 1;
      a = clr_idx;
    end else if (!clear) begin
      if (push && pop && stk.size() > 0) begin
        we = 1;
        a = stk.size() - 1;
        d = push_data;
      end else if (push && stk.size() < 8) begin
        we = 1;
        a = stk.size();
        d = push_data;
      end
    end
  endfunction
  always @(posedge clk) begin
    bit we;
    int a, n;
    logic [7:0] d;
    exp_ram(we, a, d);
    if (we) mem[a] = d;
    n = stk.size();
    if (!rst_n) begin
      stk.delete();
      clr_left = 0;
      clr_idx = 0;
      m_pv = 0;
      m_pd = 0;
      m_ovf = 0;
      m_udf = 0;
    end else if (clr_left > 0) begin
      m_pv = 0;
      clr_idx++;
      clr_left--;
      if (clr_left == 0) stk.delete();
    end else if (clear) begin
      clr_left = 8;
      clr_idx = 0;
      m_ovf = 0;
      m_udf = 0;
      m_pv = 0;
    end else begin
      m_pv = 0;
      if (push && pop && n > 0) begin
        m_pd = stk[n-1];
        m_pv = 1;
        stk[n-1] = push_data;
      end else if (push) begin
        if (n == 8) m_ovf = 1;
        else stk.push_back(push_data);
        if (pop) m_udf = 1;
      end else if (pop) begin
        if (n == 0) m_udf = 1;
        else begin
          m_pd = stk.pop_back();
          m_pv = 1;
        end
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    bit we;
    int a, n;
    logic [7:0] d;
    n = stk.size();
    exp_ram(we, a, d);
    check("depth", depth, n);
    check("full", full, n == 8);
    check("empty", empty, n == 0);
    check("busy", busy, clr_left > 0);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_udf);
    check("pop_valid", pop_valid, m_pv);
    check("pop_data", pop_data, m_pd);
    check("ram_write_en", ram_write_en, we);
    if (we) begin
      check("ram_addr", ram_addr, a);
      check("ram_data_in", ram_data_in, d);
    end
    for (int i = 0; i < 8; i++) check("ram_word", ram[i], mem[i]);
  end
  task automatic step(input bit p, input bit q, input bit c, input logic [7:0] d);
    push = p;
    pop = q;
    clear = c;
    push_data = d;
    @(posedge clk);
    #1;
    push = 0;
    pop = 0;
    clear = 0;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) begin
      ram[i] = 8'(8'hE0 + i);
      mem[i] = 8'(8'hE0 + i);
    end
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    check("rst_depth", depth, 0);
    check("rst_pop_valid", pop_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    rst_n = 1;
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    step(1, 0, 0, 8'h33);
    check("t1_depth", depth, 3);
    check("t1_ram0", ram[0], 8'h11);
    check("t1_ram1", ram[1], 8'h22);
    check("t1_ram2", ram[2], 8'h33);
    step(0, 1, 0, 0);
    check("t1_pop_data", pop_data, 8'h33);
    check("t1_pop_valid", pop_valid, 1);
    check("t1_depth2", depth, 2);
    step(1, 1, 0, 8'h99);
    check("t4_pop_data", pop_data, 8'h22);
    check("t4_pop_valid", pop_valid, 1);
    check("t4_depth", depth, 2);
    check("t4_ram1", ram[1], 8'h99);
    step(0, 1, 0, 0);
    check("t4_pop_new", pop_data, 8'h99);
    step(0, 1, 0, 0);
    check("t4_pop_old", pop_data, 8'h11);
    check("t4_empty", empty, 1);
    step(0, 1, 0, 0);
    check("t3_underflow", underflow, 1);
    check("t3_pop_valid", pop_valid, 0);
    check("t3_depth", depth, 0);
    step(1, 0, 0, 8'h05);
    step(0, 1, 0, 0);
    check("t3_pop_data", pop_data, 8'h05);
    check("t3_pop_valid", pop_valid, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 8'(8'h40 + i));
    check("t2_full", full, 1);
    check("t2_depth", depth, 8);
    push = 1;
    push_data = 8'hAA;
    #1;
    check("t2_no_write", ram_write_en, 0);
    @(posedge clk);
    #1;
    push = 0;
    check("t2_overflow", overflow, 1);
    check("t2_depth9", depth, 8);
    check("t2_ram7", ram[7], 8'h47);
    repeat (3) step(0, 1, 0, 0);
    check("t5_depth", depth, 5);
    step(0, 0, 1, 0);
    check("t5_busy", busy, 1);
    check("t5_ovf_clr", overflow, 0);
    check("t5_udf_clr", underflow, 0);
    push = 1;
    push_data = 8'h77;
    for (int k = 0; k < 8; k++) begin
      check("t5_busy_k", busy, 1);
      check("t5_addr_k", ram_addr, k);
      check("t5_we_k", ram_write_en, 1);
      check("t5_din_k", ram_data_in, 0);
      @(posedge clk);
      #1;
    end
    push = 0;
    check("t5_done", busy, 0);
    check("t5_empty", empty, 1);
    check("t5_overflow", overflow, 0);
    check("t5_underflow", underflow, 0);
    for (int i = 0; i < 8; i++) check("t5_ram_zero", ram[i], 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 8'(8'h80 + i));
    step(0, 0, 1, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;
    check("t6_busy", busy, 0);
    check("t6_depth", depth, 0);
    check("t6_pop_valid", pop_valid, 0);
    check("t6_ram0", ram[0], 0);
    check("t6_ram2", ram[2], 0);
    for (int i = 3; i < 8; i++) check("t6_ram_kept", ram[i], 8'(8'h80 + i));
    rst_n = 1;
    step(1, 0, 0, 8'h5A);
    step(0, 1, 0, 0);
    check("t6_pop_after", pop_data, 8'h5A);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
